// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int SIZE_BLOCK_DEF = 256;
  localparam int WORD_SIZE_DEF  = 32;

  // Arbiter FSM: one memory transaction in flight at a time.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Operation of the granted request; also the low bit of the ack index.
  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Within one requester a pending write is served before a pending read.
  function automatic op_e op_sel(input logic wr_rq);
    if (wr_rq) begin
      return OP_WR;
    end else begin
      return OP_RD;
    end
  endfunction

endpackage

// File: rtl/module_mem_arb_pick.sv
// Grant selection between requester 0 and requester 1.
// Build option MEM_ARB_RR_EN: round-robin with a registered pointer that
// favours the requester that was not granted last. Without it, requester 1
// has fixed priority over requester 0 and no pointer exists.
module module_mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic grant_en_i,
`endif
  input  logic req0_i,
  input  logic req1_i,
  output logic valid_o,
  output logic sel_o
);

`ifdef MEM_ARB_RR_EN
  logic ptr_q;  // 0 favours r0, 1 favours r1
  logic ptr_d;

  // Pick a requester on contention using the pointer, and advance it on a grant.
  always_comb begin
    valid_o = req0_i | req1_i;
    ptr_d   = ptr_q;
    if (req0_i && req1_i) begin
      sel_o = ptr_q;
    end else if (req1_i) begin
      sel_o = 1'b1;
    end else begin
      sel_o = 1'b0;
    end
    if (grant_en_i && valid_o) begin
      ptr_d = ~sel_o;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register; reset favours r0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: r1 wins whenever it requests.
  always_comb begin
    valid_o = req0_i | req1_i;
    if (req1_i) begin
      sel_o = 1'b1;
    end else begin
      sel_o = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/module_mem_arbiter.sv
// Two-requester memory arbiter: block reads and word writes from r0/r1 are
// serialised onto one memory port, one transaction at a time.
// Build option MEM_ARB_RR_EN selects round-robin instead of r1-priority.
module module_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int SIZE_BLOCK = SIZE_BLOCK_DEF,
  parameter int WORD_SIZE  = WORD_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_rd_rq,
  input  logic [ADDR_WIDTH-1:0] r0_rd_addr,
  output logic                  r0_rd_ack,
  output logic [SIZE_BLOCK-1:0] r0_rd_data,
  input  logic                  r0_wr_rq,
  input  logic [ADDR_WIDTH-1:0] r0_wr_addr,
  input  logic [WORD_SIZE-1:0]  r0_wr_data,
  output logic                  r0_wr_ack,
  input  logic                  r1_rd_rq,
  input  logic [ADDR_WIDTH-1:0] r1_rd_addr,
  output logic                  r1_rd_ack,
  output logic [SIZE_BLOCK-1:0] r1_rd_data,
  input  logic                  r1_wr_rq,
  input  logic [ADDR_WIDTH-1:0] r1_wr_addr,
  input  logic [WORD_SIZE-1:0]  r1_wr_data,
  output logic                  r1_wr_ack,
  output logic                  mem_rd_block_rq,
  output logic [ADDR_WIDTH-1:0] mem_rd_block_addr,
  input  logic                  mem_rd_block_ack,
  input  logic [SIZE_BLOCK-1:0] mem_rd_block_data,
  output logic                  mem_wr_bytes_rq,
  output logic [ADDR_WIDTH-1:0] mem_wr_bytes_addr,
  output logic [WORD_SIZE-1:0]  mem_wr_bytes_data,
  input  logic                  mem_wr_bytes_ack
);

  state_e                state_q, state_d;
  logic                  gnt_q, gnt_d;        // granted requester
  op_e                   op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
  logic [SIZE_BLOCK-1:0] rdata_q, rdata_d;    // shared by both rd_data ports
  logic                  mem_rd_rq_q, mem_rd_rq_d;
  logic                  mem_wr_rq_q, mem_wr_rq_d;
  logic [3:0]            ack_q, ack_d;        // {r1_wr, r1_rd, r0_wr, r0_rd}
  logic                  pick_valid;
  logic                  pick_sel;
  logic                  sel_wr;

  module_mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk        (clk),
    .rst        (rst),
    .grant_en_i (state_q == IDLE),
`endif
    .req0_i     (r0_rd_rq | r0_wr_rq),
    .req1_i     (r1_rd_rq | r1_wr_rq),
    .valid_o    (pick_valid),
    .sel_o      (pick_sel)
  );

  // Next-state and next-output logic; outputs are computed one state ahead so
  // that the registered request/ack pulses line up with ISSUE/RESP.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_rd_rq_d = 1'b0;
    mem_wr_rq_d = 1'b0;
    ack_d       = 4'b0000;
    sel_wr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d = pick_sel;
          if (pick_sel) begin
            sel_wr = r1_wr_rq;
            addr_d = r1_wr_rq ? r1_wr_addr : r1_rd_addr;
            wdata_d = r1_wr_rq ? r1_wr_data : wdata_q;
          end else begin
            sel_wr = r0_wr_rq;
            addr_d = r0_wr_rq ? r0_wr_addr : r0_rd_addr;
            wdata_d = r0_wr_rq ? r0_wr_data : wdata_q;
          end
          op_d        = op_sel(sel_wr);
          mem_rd_rq_d = (op_d == OP_RD);
          mem_wr_rq_d = (op_d == OP_WR);
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (((op_q == OP_RD) && mem_rd_block_ack) ||
            ((op_q == OP_WR) && mem_wr_bytes_ack)) begin
          if (op_q == OP_RD) begin
            rdata_d = mem_rd_block_data;
          end else begin
            rdata_d = rdata_q;
          end
          ack_d   = 4'b0001 << {gnt_q, op_q};
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      op_q        <= OP_RD;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      wdata_q     <= {WORD_SIZE{1'b0}};
      rdata_q     <= {SIZE_BLOCK{1'b0}};
      mem_rd_rq_q <= 1'b0;
      mem_wr_rq_q <= 1'b0;
      ack_q       <= 4'b0000;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_rd_rq_q <= mem_rd_rq_d;
      mem_wr_rq_q <= mem_wr_rq_d;
      ack_q       <= ack_d;
    end
  end

  assign r0_rd_ack         = ack_q[0];
  assign r0_wr_ack         = ack_q[1];
  assign r1_rd_ack         = ack_q[2];
  assign r1_wr_ack         = ack_q[3];
  assign r0_rd_data        = rdata_q;
  assign r1_rd_data        = rdata_q;
  assign mem_rd_block_rq   = mem_rd_rq_q;
  assign mem_rd_block_addr = addr_q;
  assign mem_wr_bytes_rq   = mem_wr_rq_q;
  assign mem_wr_bytes_addr = addr_q;
  assign mem_wr_bytes_data = wdata_q;

endmodule

// File: tb/tb_module_mem_arbiter.sv
// Directed testbench for module_mem_arbiter with a small memory model.
module tb_module_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 16;
  localparam int SB = 256;
  localparam int WS = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_rd_rq, r0_wr_rq, r1_rd_rq, r1_wr_rq;
  logic [AW-1:0] r0_rd_addr, r0_wr_addr, r1_rd_addr, r1_wr_addr;
  logic [WS-1:0] r0_wr_data, r1_wr_data;
  logic          r0_rd_ack, r0_wr_ack, r1_rd_ack, r1_wr_ack;
  logic [SB-1:0] r0_rd_data, r1_rd_data;
  logic          mem_rd_block_rq, mem_wr_bytes_rq;
  logic [AW-1:0] mem_rd_block_addr, mem_wr_bytes_addr;
  logic [WS-1:0] mem_wr_bytes_data;
  logic          mem_rd_block_ack = 1'b0;
  logic [SB-1:0] mem_rd_block_data = '0;
  logic          mem_wr_bytes_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  int mem_delay = 0;
  int n_mem_rd = 0;
  int n_mem_wr = 0;
  int n_mem_ack = 0;

  // memory model state
  logic          rd_pend = 1'b0;
  int            rd_cnt = 0;
  logic [AW-1:0] rd_a = '0;
  logic          have_wr = 1'b0;
  logic [AW-1:0] wr_a = '0;
  logic [WS-1:0] wr_d = '0;

  always #5 clk = ~clk;

  module_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_rd_rq(r0_rd_rq), .r0_rd_addr(r0_rd_addr), .r0_rd_ack(r0_rd_ack), .r0_rd_data(r0_rd_data),
    .r0_wr_rq(r0_wr_rq), .r0_wr_addr(r0_wr_addr), .r0_wr_data(r0_wr_data), .r0_wr_ack(r0_wr_ack),
    .r1_rd_rq(r1_rd_rq), .r1_rd_addr(r1_rd_addr), .r1_rd_ack(r1_rd_ack), .r1_rd_data(r1_rd_data),
    .r1_wr_rq(r1_wr_rq), .r1_wr_addr(r1_wr_addr), .r1_wr_data(r1_wr_data), .r1_wr_ack(r1_wr_ack),
    .mem_rd_block_rq(mem_rd_block_rq), .mem_rd_block_addr(mem_rd_block_addr),
    .mem_rd_block_ack(mem_rd_block_ack), .mem_rd_block_data(mem_rd_block_data),
    .mem_wr_bytes_rq(mem_wr_bytes_rq), .mem_wr_bytes_addr(mem_wr_bytes_addr),
    .mem_wr_bytes_data(mem_wr_bytes_data), .mem_wr_bytes_ack(mem_wr_bytes_ack)
  );

  // Memory contents: word i of a block is {16'hB10C, addr} + i, patched by the last write.
  function automatic logic [SB-1:0] mem_read(input logic [AW-1:0] a, input logic hw,
                                             input logic [AW-1:0] wa, input logic [WS-1:0] wd);
    logic [SB-1:0] b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = {16'hB10C, a} + 32'(i);
    if (hw && (wa[15:5] == a[15:5])) b[int'(wa[4:0]) * 8 +: 32] = wd;
    return b;
  endfunction

  // Memory responder: ack mem_delay cycles after sampling a request (0 = next cycle).
  always @(posedge clk) begin
    mem_rd_block_ack <= 1'b0;
    mem_wr_bytes_ack <= 1'b0;
    if (mem_rd_block_rq) n_mem_rd <= n_mem_rd + 1;
    if (mem_wr_bytes_rq) n_mem_wr <= n_mem_wr + 1;
    if (mem_rd_block_ack) n_mem_ack <= n_mem_ack + 1;
    if (mem_rd_block_rq) begin
      if (mem_delay == 0) begin
        mem_rd_block_ack  <= 1'b1;
        mem_rd_block_data <= mem_read(mem_rd_block_addr, have_wr, wr_a, wr_d);
      end else begin
        rd_pend <= 1'b1;
        rd_cnt  <= mem_delay - 1;
        rd_a    <= mem_rd_block_addr;
      end
    end else if (rd_pend) begin
      if (rd_cnt == 0) begin
        mem_rd_block_ack  <= 1'b1;
        mem_rd_block_data <= mem_read(rd_a, have_wr, wr_a, wr_d);
        rd_pend           <= 1'b0;
      end else begin
        rd_cnt <= rd_cnt - 1;
      end
    end
    if (mem_wr_bytes_rq) begin
      mem_wr_bytes_ack <= 1'b1;
      have_wr          <= 1'b1;
      wr_a             <= mem_wr_bytes_addr;
      wr_d             <= mem_wr_bytes_data;
    end
  end

  // Waits (bounded) for any ack in mask; returns the ack vector {r1_wr,r1_rd,r0_wr,r0_rd}.
  task automatic wait_ack(input logic [3:0] mask, output logic [3:0] seen, output bit timeout);
    timeout = 1'b1;
    seen = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen = {r1_wr_ack, r1_rd_ack, r0_wr_ack, r0_rd_ack};
      if ((seen & mask) != 4'b0000) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    r0_rd_rq = 1'b0; r0_wr_rq = 1'b0; r1_rd_rq = 1'b0; r1_wr_rq = 1'b0;
    r0_rd_addr = '0; r0_wr_addr = '0; r1_rd_addr = '0; r1_wr_addr = '0;
    r0_wr_data = '0; r1_wr_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({r0_rd_ack, r0_wr_ack, r1_rd_ack, r1_wr_ack, mem_rd_block_rq, mem_wr_bytes_rq} !== 6'b0) begin
      errors++; $display("FAIL reset_ctl got %b want 000000",
        {r0_rd_ack, r0_wr_ack, r1_rd_ack, r1_wr_ack, mem_rd_block_rq, mem_wr_bytes_rq});
    end
    checks++;
    if ({r0_rd_data, mem_rd_block_addr, mem_wr_bytes_data} !== '0) begin
      errors++; $display("FAIL reset_data got nonzero rd_data=%h addr=%h wdata=%h",
        r0_rd_data, mem_rd_block_addr, mem_wr_bytes_data);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++; $display("FAIL reset_state got %0d want %0d", dut.state_q, IDLE);
    end
    rst = 1'b0;
  endtask

  task automatic test_read_latency;
    int n0;
    logic [SB-1:0] exp;
    exp = {32'hB10C0047, 32'hB10C0046, 32'hB10C0045, 32'hB10C0044,
           32'hB10C0043, 32'hB10C0042, 32'hB10C0041, 32'hB10C0040};
    @(negedge clk);
    n0 = n_mem_rd;
    r0_rd_rq = 1'b1; r0_rd_addr = 16'h0040;
    @(negedge clk);
    checks++;
    if ({mem_rd_block_rq, mem_rd_block_addr, r0_rd_ack} !== {1'b1, 16'h0040, 1'b0}) begin
      errors++; $display("FAIL rd_issue got rq=%b addr=%h ack=%b want 1 0040 0",
        mem_rd_block_rq, mem_rd_block_addr, r0_rd_ack);
    end
    @(negedge clk);
    checks++;
    if ({mem_rd_block_rq, r0_rd_ack} !== 2'b00) begin
      errors++; $display("FAIL rd_wait got rq=%b ack=%b want 0 0", mem_rd_block_rq, r0_rd_ack);
    end
    @(negedge clk);
    checks++;
    if (r0_rd_ack !== 1'b1) begin
      errors++; $display("FAIL rd_ack_latency got %b want 1", r0_rd_ack);
    end
    checks++;
    if ((r0_rd_data !== exp) || (r1_rd_data !== exp)) begin
      errors++; $display("FAIL rd_data got %h / %h want %h", r0_rd_data, r1_rd_data, exp);
    end
    r0_rd_rq = 1'b0;
    @(negedge clk);
    checks++;
    if ({r0_rd_ack, r1_rd_ack} !== 2'b00) begin
      errors++; $display("FAIL rd_ack_pulse got %b%b want 00", r0_rd_ack, r1_rd_ack);
    end
    checks++;
    if (r0_rd_data !== exp) begin
      errors++; $display("FAIL rd_data_hold got %h want %h", r0_rd_data, exp);
    end
    checks++;
    if (n_mem_rd - n0 !== 1) begin
      errors++; $display("FAIL rd_pulse_count got %0d want 1", n_mem_rd - n0);
    end
  endtask

  task automatic test_write;
    int n0;
    logic [3:0] seen;
    bit to;
    @(negedge clk);
    n0 = n_mem_wr;
    r1_wr_rq = 1'b1; r1_wr_addr = 16'h0100; r1_wr_data = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({mem_wr_bytes_rq, mem_wr_bytes_addr, mem_wr_bytes_data} !== {1'b1, 16'h0100, 32'hDEADBEEF}) begin
      errors++; $display("FAIL wr_issue got rq=%b addr=%h data=%h want 1 0100 deadbeef",
        mem_wr_bytes_rq, mem_wr_bytes_addr, mem_wr_bytes_data);
    end
    wait_ack(4'b1111, seen, to);
    checks++;
    if (to || (seen !== 4'b1000)) begin
      errors++; $display("FAIL wr_ack got %b timeout=%0d want 1000", seen, to);
    end
    r1_wr_rq = 1'b0;
    @(negedge clk);
    checks++;
    if ((r1_wr_ack !== 1'b0) || (n_mem_wr - n0 !== 1)) begin
      errors++; $display("FAIL wr_pulse got ack=%b count=%0d want 0 1", r1_wr_ack, n_mem_wr - n0);
    end
    r0_rd_rq = 1'b1; r0_rd_addr = 16'h0100;
    wait_ack(4'b0001, seen, to);
    r0_rd_rq = 1'b0;
    checks++;
    if (to || ({r0_rd_data[7:0], r0_rd_data[15:8], r0_rd_data[23:16], r0_rd_data[31:24]} !== 32'hEFBEADDE)) begin
      errors++; $display("FAIL wr_readback got %h timeout=%0d want bytes EFBEADDE", r0_rd_data[31:0], to);
    end
    checks++;
    if (r0_rd_data[63:32] !== 32'hB10C0101) begin
      errors++; $display("FAIL wr_readback_w1 got %h want b10c0101", r0_rd_data[63:32]);
    end
  endtask

  task automatic test_wr_before_rd;
    int nr, nw;
    logic [3:0] seen;
    bit to;
    @(negedge clk);
    nr = n_mem_rd; nw = n_mem_wr;
    r0_wr_rq = 1'b1; r0_wr_addr = 16'h0060; r0_wr_data = 32'h12345678;
    r0_rd_rq = 1'b1; r0_rd_addr = 16'h0080;
    wait_ack(4'b0011, seen, to);
    checks++;
    if (to || (seen !== 4'b0010)) begin
      errors++; $display("FAIL rw_first got %b timeout=%0d want 0010", seen, to);
    end
    r0_wr_rq = 1'b0;
    wait_ack(4'b0011, seen, to);
    r0_rd_rq = 1'b0;
    checks++;
    if (to || (seen !== 4'b0001) || (r0_rd_data[31:0] !== 32'hB10C0080)) begin
      errors++; $display("FAIL rw_second got %b data=%h timeout=%0d want 0001 b10c0080",
        seen, r0_rd_data[31:0], to);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ((n_mem_rd - nr !== 1) || (n_mem_wr - nw !== 1)) begin
      errors++; $display("FAIL rw_pulses got rd=%0d wr=%0d want 1 1", n_mem_rd - nr, n_mem_wr - nw);
    end
  endtask

  task automatic test_arbitration;
    logic [3:0] seen;
    logic [3:0] exp;
    logic [31:0] exp_w;
    bit to;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    r0_rd_rq = 1'b1; r0_rd_addr = 16'h0020;
    r1_rd_rq = 1'b1; r1_rd_addr = 16'h00A0;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      exp = (k % 2 == 0) ? 4'b0001 : 4'b0100;
`else
      exp = 4'b0100;
`endif
      exp_w = (exp == 4'b0001) ? 32'hB10C0020 : 32'hB10C00A0;
      wait_ack(4'b0101, seen, to);
      checks++;
      if (to || (seen !== exp) || (r0_rd_data[31:0] !== exp_w)) begin
        errors++; $display("FAIL arb_grant%0d got %b data=%h timeout=%0d want %b %h",
          k, seen, r0_rd_data[31:0], to, exp, exp_w);
      end
    end
    r0_rd_rq = 1'b0; r1_rd_rq = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int na;
    bit dirty;
    @(negedge clk);
    mem_delay = 3;
    r0_rd_rq = 1'b1; r0_rd_addr = 16'h0040;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dut.state_q !== WAIT) begin
      errors++; $display("FAIL rstmid_in_wait got %0d want %0d", dut.state_q, WAIT);
    end
    na = n_mem_ack;
    rst = 1'b1; r0_rd_rq = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    dirty = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if ({r0_rd_ack, r0_wr_ack, r1_rd_ack, r1_wr_ack, mem_rd_block_rq, mem_wr_bytes_rq,
           mem_rd_block_addr, mem_wr_bytes_addr, mem_wr_bytes_data, r0_rd_data, r1_rd_data} !== '0)
        dirty = 1'b1;
    end
    checks++;
    if (dirty !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs got nonzero output after reset want all 0");
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++; $display("FAIL rstmid_state got %0d want %0d", dut.state_q, IDLE);
    end
    checks++;
    if (n_mem_ack - na !== 1) begin
      errors++; $display("FAIL rstmid_late_ack got %0d memory acks want 1", n_mem_ack - na);
    end
    mem_delay = 0;
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write();
    test_wr_before_rd();
    test_arbitration();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
